// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if -- bundle of every client and memory handshake signal
// around the two-client memory port arbiter.
//
// Signals:
//   c0_*/c1_*   : per-client write channel (in_addr/in_data/in_valid/in_ready)
//                 and read channel (out_addr/out_valid/out_data/out_ready)
//   main_mem_*  : downstream memory write channel (main_mem_in_*) and read
//                 channel (main_mem_out_*)
// Modports:
//   master : the arbiter's view (drives client readies/read data and the
//            downstream request side)
//   slave  : the environment's view (clients plus memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] c0_in_addr;
  logic [DATA_W-1:0] c0_in_data;
  logic              c0_in_valid;
  logic              c0_in_ready;
  logic [ADDR_W-1:0] c0_out_addr;
  logic              c0_out_valid;
  logic [DATA_W-1:0] c0_out_data;
  logic              c0_out_ready;

  logic [ADDR_W-1:0] c1_in_addr;
  logic [DATA_W-1:0] c1_in_data;
  logic              c1_in_valid;
  logic              c1_in_ready;
  logic [ADDR_W-1:0] c1_out_addr;
  logic              c1_out_valid;
  logic [DATA_W-1:0] c1_out_data;
  logic              c1_out_ready;

  logic [ADDR_W-1:0] main_mem_in_addr;
  logic [DATA_W-1:0] main_mem_in_data;
  logic              main_mem_in_valid;
  logic              main_mem_in_ready;
  logic [ADDR_W-1:0] main_mem_out_addr;
  logic              main_mem_out_valid;
  logic [DATA_W-1:0] main_mem_out_data;
  logic              main_mem_out_ready;

  modport master (
    input  c0_in_addr, c0_in_data, c0_in_valid, c0_out_addr, c0_out_valid,
    output c0_in_ready, c0_out_data, c0_out_ready,
    input  c1_in_addr, c1_in_data, c1_in_valid, c1_out_addr, c1_out_valid,
    output c1_in_ready, c1_out_data, c1_out_ready,
    output main_mem_in_addr, main_mem_in_data, main_mem_in_valid,
    input  main_mem_in_ready,
    output main_mem_out_addr, main_mem_out_valid,
    input  main_mem_out_data, main_mem_out_ready
  );

  modport slave (
    output c0_in_addr, c0_in_data, c0_in_valid, c0_out_addr, c0_out_valid,
    input  c0_in_ready, c0_out_data, c0_out_ready,
    output c1_in_addr, c1_in_data, c1_in_valid, c1_out_addr, c1_out_valid,
    input  c1_in_ready, c1_out_data, c1_out_ready,
    input  main_mem_in_addr, main_mem_in_data, main_mem_in_valid,
    output main_mem_in_ready,
    input  main_mem_out_addr, main_mem_out_valid,
    output main_mem_out_data, main_mem_out_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one memory port (write + read channel) between
// two clients. One transfer is granted at a time; a client's write is served
// before its own read.
//
// Ports:
//   clk      : clock, all state changes on rising edge
//   reset    : synchronous active-high reset
//   bus      : mem_port_arbiter_if.master, client and memory handshakes
//   busy     : a transfer is currently granted
//   grant_id : index of the granted client (registered)
//
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN defined   -> round-robin between simultaneous
//                                       requesters (1-bit priority pointer)
//   MEM_ARB_ROUND_ROBIN_EN undefined -> fixed priority, client 0 wins
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus,
  output logic                busy,
  output logic                grant_id
);

  typedef enum logic [1:0] {IDLE, GRANT_WR, GRANT_RD} state_t;

  state_t state_reg, state_next;
  logic   grant_reg, grant_next;

  logic [1:0]        in_valid, out_valid, req, in_ready, out_ready;
  logic [ADDR_W-1:0] in_addr  [2];
  logic [ADDR_W-1:0] out_addr [2];
  logic [DATA_W-1:0] in_data  [2];
  logic              prio, winner;

  logic              mm_in_valid, mm_out_valid;
  logic [ADDR_W-1:0] mm_in_addr, mm_out_addr;
  logic [DATA_W-1:0] mm_in_data;

  assign in_valid    = {bus.c1_in_valid, bus.c0_in_valid};
  assign out_valid   = {bus.c1_out_valid, bus.c0_out_valid};
  assign in_addr[0]  = bus.c0_in_addr;
  assign in_addr[1]  = bus.c1_in_addr;
  assign in_data[0]  = bus.c0_in_data;
  assign in_data[1]  = bus.c1_in_data;
  assign out_addr[0] = bus.c0_out_addr;
  assign out_addr[1] = bus.c1_out_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      assign req[gi]       = in_valid[gi] | out_valid[gi];
      // Only the granted channel sees the memory's ready.
      assign in_ready[gi]  = (state_reg == GRANT_WR) && (grant_reg == 1'(gi))
                             && bus.main_mem_in_ready;
      assign out_ready[gi] = (state_reg == GRANT_RD) && (grant_reg == 1'(gi))
                             && bus.main_mem_out_ready;
    end
  endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr_reg names the client that wins the next contention.
  logic ptr_reg, ptr_next;
  assign prio = ptr_reg;
`else
  assign prio = 1'b0;
`endif

  // With a single requester it wins outright; with two, prio decides.
  assign winner = (req[0] && req[1]) ? prio : req[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_reg   <= ptr_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_next     = ptr_reg;
`endif
    mm_in_valid  = 1'b0;
    mm_in_addr   = '0;
    mm_in_data   = '0;
    mm_out_valid = 1'b0;
    mm_out_addr  = '0;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next = winner;
          state_next = in_valid[winner] ? GRANT_WR : GRANT_RD;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_next   = ~winner;
`endif
        end
      end
      GRANT_WR: begin
        mm_in_valid = in_valid[grant_reg];
        mm_in_addr  = in_addr[grant_reg];
        mm_in_data  = in_data[grant_reg];
        // Completion or abort (client dropped valid) both return to IDLE.
        if (!in_valid[grant_reg] || bus.main_mem_in_ready) state_next = IDLE;
      end
      GRANT_RD: begin
        mm_out_valid = out_valid[grant_reg];
        mm_out_addr  = out_addr[grant_reg];
        if (!out_valid[grant_reg] || bus.main_mem_out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.main_mem_in_valid  = mm_in_valid;
  assign bus.main_mem_in_addr   = mm_in_addr;
  assign bus.main_mem_in_data   = mm_in_data;
  assign bus.main_mem_out_valid = mm_out_valid;
  assign bus.main_mem_out_addr  = mm_out_addr;

  assign bus.c0_in_ready  = in_ready[0];
  assign bus.c1_in_ready  = in_ready[1];
  assign bus.c0_out_ready = out_ready[0];
  assign bus.c1_out_ready = out_ready[1];
  assign bus.c0_out_data  = bus.main_mem_out_data;
  assign bus.c1_out_data  = bus.main_mem_out_data;

  assign busy     = (state_reg != IDLE);
  assign grant_id = grant_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter -- self-checking bench for mem_port_arbiter.
// Directed scenarios plus randomized rounds; the expected grant order comes
// from a transaction-level model (pending write/read per client, priority rule).
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic busy, grant_id;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .grant_id(grant_id)
  );

  wire [1:0] in_ready  = {bus.c1_in_ready, bus.c0_in_ready};
  wire [1:0] out_ready = {bus.c1_out_ready, bus.c0_out_ready};

  int tests_run = 0;
  int tests_failed = 0;

  logic          want_w [2];
  logic          want_r [2];
  logic [AW-1:0] waddr  [2];
  logic [AW-1:0] raddr  [2];
  logic [DW-1:0] wdata  [2];
  int            model_ptr;
  int            exp_client [$];
  bit            exp_wr     [$];
  int            act_grants [$];

  task automatic drive_clients();
    bus.c0_in_valid  = want_w[0]; bus.c0_in_addr  = waddr[0]; bus.c0_in_data = wdata[0];
    bus.c1_in_valid  = want_w[1]; bus.c1_in_addr  = waddr[1]; bus.c1_in_data = wdata[1];
    bus.c0_out_valid = want_r[0]; bus.c0_out_addr = raddr[0];
    bus.c1_out_valid = want_r[1]; bus.c1_out_addr = raddr[1];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      want_w[k] = 0; want_r[k] = 0; waddr[k] = '0; raddr[k] = '0; wdata[k] = '0;
    end
    drive_clients();
    bus.main_mem_in_ready = 0; bus.main_mem_out_ready = 0; bus.main_mem_out_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_ptr = 0;
  endtask

  // Serve order for requests all raised together: the winner of each
  // arbitration does its write first, then its read at a later arbitration.
  function automatic void model_order();
    bit pw[2], pr[2];
    int win;
    for (int k = 0; k < 2; k++) begin pw[k] = want_w[k]; pr[k] = want_r[k]; end
    exp_client.delete(); exp_wr.delete();
    while (pw[0] || pr[0] || pw[1] || pr[1]) begin
      if ((pw[0] || pr[0]) && (pw[1] || pr[1])) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = model_ptr;
`else
        win = 0;
`endif
      end else begin
        win = (pw[1] || pr[1]) ? 1 : 0;
      end
      exp_client.push_back(win);
      if (pw[win]) begin exp_wr.push_back(1'b1); pw[win] = 0; end
      else begin exp_wr.push_back(1'b0); pr[win] = 0; end
      model_ptr = 1 - win;
    end
  endfunction

  // Runs one round from IDLE: all wanted requests are raised together and the
  // memory answers after lat valid cycles (lat < 0: random ready).
  task automatic run_round(input int lat, input bit fixed_rd, input logic [DW-1:0] rd_val);
    int phase, vcnt, cyc, k;
    int ready_cnt[2], exp_cnt[2];
    bit wr, rdy, drop;
    logic [DW-1:0] rd_now;
    logic [AW-1:0] e_iaddr, e_oaddr;
    logic [DW-1:0] e_idata;
    logic [1:0] e_inr, e_outr;
    model_order();
    for (int c = 0; c < 2; c++) begin
      ready_cnt[c] = 0;
      exp_cnt[c] = int'(want_w[c]) + int'(want_r[c]);
    end
    drive_clients();
    phase = 0; vcnt = 0; cyc = 0;
    while (exp_client.size() > 0 && cyc < 300) begin
      cyc++;
      drop = 0;
      @(negedge clk);
      rdy = (lat < 0) ? ($urandom_range(0, 2) == 0) : (vcnt >= lat);
      rd_now = fixed_rd ? rd_val : DW'($urandom);
      bus.main_mem_in_ready = rdy; bus.main_mem_out_ready = rdy; bus.main_mem_out_data = rd_now;
      #1;
      ready_cnt[0] += int'(in_ready[0]) + int'(out_ready[0]);
      ready_cnt[1] += int'(in_ready[1]) + int'(out_ready[1]);
      k = exp_client[0]; wr = exp_wr[0];
      if (phase == 0) begin
        tests_run++;
        if (busy !== 1'b0 || bus.main_mem_in_valid !== 1'b0 || bus.main_mem_out_valid !== 1'b0 ||
            in_ready !== 2'b00 || out_ready !== 2'b00 || bus.main_mem_in_addr !== '0 ||
            bus.main_mem_in_data !== '0 || bus.main_mem_out_addr !== '0) begin
          tests_failed++;
          $display("FAIL idle_gap: busy=%b iv=%b ov=%b ir=%b or=%b ia=%h id=%h oa=%h, required all 0",
                   busy, bus.main_mem_in_valid, bus.main_mem_out_valid, in_ready, out_ready,
                   bus.main_mem_in_addr, bus.main_mem_in_data, bus.main_mem_out_addr);
        end
        phase = 1;
      end else begin
        if (phase == 1) begin act_grants.push_back(int'(grant_id)); phase = 2; end
        e_iaddr = wr ? waddr[k] : '0;
        e_idata = wr ? wdata[k] : '0;
        e_oaddr = wr ? '0 : raddr[k];
        e_inr = 2'b00; e_outr = 2'b00;
        if (rdy && wr) e_inr[k] = 1'b1;
        if (rdy && !wr) e_outr[k] = 1'b1;
        tests_run++;
        if (busy !== 1'b1 || grant_id !== 1'(k) || bus.main_mem_in_valid !== wr ||
            bus.main_mem_out_valid !== !wr) begin
          tests_failed++;
          $display("FAIL grant: busy=%b gid=%b iv=%b ov=%b, required busy=1 gid=%0d iv=%b ov=%b",
                   busy, grant_id, bus.main_mem_in_valid, bus.main_mem_out_valid, k, wr, !wr);
        end
        tests_run++;
        if (bus.main_mem_in_addr !== e_iaddr || bus.main_mem_in_data !== e_idata ||
            bus.main_mem_out_addr !== e_oaddr || in_ready !== e_inr || out_ready !== e_outr ||
            bus.c0_out_data !== rd_now || bus.c1_out_data !== rd_now) begin
          tests_failed++;
          $display("FAIL route: ia=%h id=%h oa=%h ir=%b or=%b d0=%h d1=%h, required ia=%h id=%h oa=%h ir=%b or=%b d=%h",
                   bus.main_mem_in_addr, bus.main_mem_in_data, bus.main_mem_out_addr, in_ready,
                   out_ready, bus.c0_out_data, bus.c1_out_data, e_iaddr, e_idata, e_oaddr,
                   e_inr, e_outr, rd_now);
        end
        vcnt++;
        if (rdy) begin
          $display("[TB] transfer client=%0d %s addr=%h data=%h", k, wr ? "write" : "read",
                   wr ? e_iaddr : e_oaddr, wr ? e_idata : rd_now);
          if (wr) want_w[k] = 0; else want_r[k] = 0;
          void'(exp_client.pop_front()); void'(exp_wr.pop_front());
          phase = 0; vcnt = 0; drop = 1;
        end
      end
      @(posedge clk);
      #1 if (drop) drive_clients();
    end
    if (exp_client.size() != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL timeout: %0d transfers left, required 0", exp_client.size());
      do_reset();
    end
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (ready_cnt[c] != exp_cnt[c]) begin
        tests_failed++;
        $display("FAIL ready_pulses c%0d: got %0d, required %0d", c, ready_cnt[c], exp_cnt[c]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    want_w[0] = 0; want_r[0] = 1; raddr[0] = 32'h44;
    want_w[1] = 1; want_r[1] = 0; waddr[1] = 32'h88; wdata[1] = 32'h1;
    drive_clients();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (busy !== 0 || grant_id !== 0 || bus.main_mem_in_valid !== 0 || bus.main_mem_out_valid !== 0 ||
        in_ready !== 0 || out_ready !== 0 || bus.main_mem_in_addr !== 0 || bus.main_mem_out_addr !== 0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b gid=%b iv=%b ov=%b ir=%b or=%b, required all 0",
               busy, grant_id, bus.main_mem_in_valid, bus.main_mem_out_valid, in_ready, out_ready);
    end
    @(negedge clk); #1;
    tests_run++;
    if (busy !== 1 || grant_id !== 0 || bus.main_mem_out_valid !== 1 || bus.main_mem_out_addr !== 32'h44) begin
      tests_failed++;
      $display("FAIL reset_first_grant: busy=%b gid=%b ov=%b oa=%h, required 1 0 1 00000044",
               busy, grant_id, bus.main_mem_out_valid, bus.main_mem_out_addr);
    end
    $display("[TB] reset check done");
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    want_w[0] = 1; waddr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    run_round(3, 0, '0);
  endtask

  task automatic test_single_read();
    do_reset();
    want_r[1] = 1; raddr[1] = 32'h20;
    run_round(1, 1, 32'h12345678);
  endtask

  task automatic test_contention();
    do_reset();
    act_grants.delete();
    for (int i = 0; i < 4; i++) begin
      want_r[0] = 1; want_r[1] = 1; raddr[0] = AW'($urandom); raddr[1] = AW'($urandom);
      run_round(-1, 0, '0);
    end
    for (int j = 0; j < act_grants.size(); j++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      tests_run++;
      if (act_grants[j] != j % 2) begin
        tests_failed++;
        $display("FAIL contention_rr grant %0d: got %0d, required %0d", j, act_grants[j], j % 2);
      end
`else
      if (j % 2 == 0) begin
        tests_run++;
        if (act_grants[j] != 0) begin
          tests_failed++;
          $display("FAIL contention_fixed grant %0d: got %0d, required 0", j, act_grants[j]);
        end
      end
`endif
    end
  endtask

  task automatic test_write_before_read();
    do_reset();
    want_w[0] = 1; waddr[0] = 32'h4; wdata[0] = AW'($urandom);
    want_r[0] = 1; raddr[0] = 32'h8;
    run_round(-1, 0, '0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    want_r[1] = 1; raddr[1] = 32'h20;
    drive_clients();
    @(negedge clk); @(negedge clk); #1;
    tests_run++;
    if (busy !== 1 || grant_id !== 1 || bus.main_mem_out_valid !== 1) begin
      tests_failed++;
      $display("FAIL midreset_pre: busy=%b gid=%b ov=%b, required 1 1 1", busy, grant_id, bus.main_mem_out_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (busy !== 0 || grant_id !== 0 || bus.main_mem_out_valid !== 0 || out_ready !== 0) begin
      tests_failed++;
      $display("FAIL midreset_post: busy=%b gid=%b ov=%b or=%b, required 0 0 0 00",
               busy, grant_id, bus.main_mem_out_valid, out_ready);
    end
    @(negedge clk); #1;
    tests_run++;
    if (busy !== 1 || grant_id !== 1 || bus.main_mem_out_valid !== 1 || bus.main_mem_out_addr !== 32'h20) begin
      tests_failed++;
      $display("FAIL midreset_regrant: busy=%b gid=%b ov=%b oa=%h, required 1 1 1 00000020",
               busy, grant_id, bus.main_mem_out_valid, bus.main_mem_out_addr);
    end
    $display("[TB] mid-transaction reset done");
    do_reset();
  endtask

  task automatic test_abort();
    do_reset();
    want_r[1] = 1; raddr[1] = 32'h30;
    drive_clients();
    @(negedge clk); @(negedge clk); #1;
    tests_run++;
    if (grant_id !== 1 || bus.main_mem_out_valid !== 1) begin
      tests_failed++;
      $display("FAIL abort_pre: gid=%b ov=%b, required 1 1", grant_id, bus.main_mem_out_valid);
    end
    @(posedge clk); #1;
    want_r[1] = 0; want_w[0] = 1; waddr[0] = 32'h44; wdata[0] = DW'($urandom);
    drive_clients();
    @(negedge clk); #1;
    tests_run++;
    if (bus.main_mem_out_valid !== 0 || out_ready !== 0 || in_ready !== 0) begin
      tests_failed++;
      $display("FAIL abort_same_cycle: ov=%b or=%b ir=%b, required 0 00 00",
               bus.main_mem_out_valid, out_ready, in_ready);
    end
    @(negedge clk); #1;
    tests_run++;
    if (busy !== 0 || bus.main_mem_in_valid !== 0) begin
      tests_failed++;
      $display("FAIL abort_idle: busy=%b iv=%b, required 0 0", busy, bus.main_mem_in_valid);
    end
    @(negedge clk);
    bus.main_mem_in_ready = 1;
    #1;
    tests_run++;
    if (busy !== 1 || grant_id !== 0 || bus.main_mem_in_valid !== 1 || bus.main_mem_in_addr !== 32'h44 ||
        bus.main_mem_in_data !== wdata[0] || in_ready !== 2'b01) begin
      tests_failed++;
      $display("FAIL abort_next_grant: busy=%b gid=%b iv=%b ia=%h id=%h ir=%b, required 1 0 1 00000044 %h 01",
               busy, grant_id, bus.main_mem_in_valid, bus.main_mem_in_addr, bus.main_mem_in_data,
               in_ready, wdata[0]);
    end
    @(posedge clk); #1;
    want_w[0] = 0; drive_clients();
    @(negedge clk); #1;
    tests_run++;
    if (busy !== 0) begin
      tests_failed++;
      $display("FAIL abort_done: busy=%b, required 0", busy);
    end
    $display("[TB] abort scenario done");
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 40; r++) begin
      do begin
        for (int k = 0; k < 2; k++) begin
          want_w[k] = 1'($urandom); want_r[k] = 1'($urandom);
          waddr[k] = AW'($urandom); raddr[k] = AW'($urandom); wdata[k] = DW'($urandom);
        end
      end while (!(want_w[0] || want_r[0] || want_w[1] || want_r[1]));
      run_round(-1, 0, '0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.main_mem_in_ready = 0; bus.main_mem_out_ready = 0; bus.main_mem_out_data = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_write_before_read();
    test_reset_mid();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
